// File: rtl/aukv_wb_data_bridge.sv
// Bridges the aukv core's native data-memory port to a Wishbone classic master,
// with a one-entry pending buffer, a per-transaction timeout and a local zero-strobe write path.
module aukv_wb_data_bridge #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    TIMEOUT_CYCLES = 256,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic                    sys_clk,
  input  logic                    rst_n,
  input  logic                    req_en_i,
  input  logic                    req_we_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_strobe_i,
  output logic                    rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    busy_o,
  output logic                    overflow_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN     = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    LOCAL  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
  logic                    pend_valid_q, pend_valid_d;
  logic                    pend_we_q, pend_we_d;
  logic [ADDR_WIDTH-1:0]   pend_addr_q, pend_addr_d;
  logic [DATA_WIDTH-1:0]   pend_wdata_q, pend_wdata_d;
  logic [SEL_WIDTH-1:0]    pend_strobe_q, pend_strobe_d;
  logic                    cyc_q, cyc_d;
  logic                    we_q, we_d;
  logic [SEL_WIDTH-1:0]    sel_q, sel_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    busy_q, busy_d;
  logic                    overflow_q, overflow_d;

  // Request chosen in IDLE: the buffered entry always takes priority over the live one.
  logic                    pick_we;
  logic [ADDR_WIDTH-1:0]   pick_addr;
  logic [DATA_WIDTH-1:0]   pick_wdata;
  logic [SEL_WIDTH-1:0]    pick_strobe;

  assign pick_we     = pend_valid_q ? pend_we_q     : req_we_i;
  assign pick_addr   = pend_valid_q ? pend_addr_q   : req_addr_i;
  assign pick_wdata  = pend_valid_q ? pend_wdata_q  : req_wdata_i;
  assign pick_strobe = pend_valid_q ? pend_strobe_q : req_strobe_i;
  assign cnt_inc     = cnt_q + CNT_W'(1);

  // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pend_valid_d  = pend_valid_q;
    pend_we_d     = pend_we_q;
    pend_addr_d   = pend_addr_q;
    pend_wdata_d  = pend_wdata_q;
    pend_strobe_d = pend_strobe_q;
    cyc_d         = cyc_q;
    we_d          = we_q;
    sel_d         = sel_q;
    adr_d         = adr_q;
    dat_d         = dat_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = '0;
    rsp_err_d     = 1'b0;
    overflow_d    = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (pend_valid_q || req_en_i) begin
          if (pick_we && (pick_strobe == '0)) begin
            state_d = LOCAL;
          end else begin
            state_d = ACTIVE;
            cyc_d   = 1'b1;
            we_d    = pick_we;
            sel_d   = pick_we ? pick_strobe : '1;
            adr_d   = pick_addr;
            dat_d   = pick_wdata;
            cnt_d   = '0;
          end
          // A live request arriving while the buffered one launches takes its slot.
          if (pend_valid_q) begin
            pend_valid_d = req_en_i;
            if (req_en_i) begin
              pend_we_d     = req_we_i;
              pend_addr_d   = req_addr_i;
              pend_wdata_d  = req_wdata_i;
              pend_strobe_d = req_strobe_i;
            end
          end
        end
      end

      ACTIVE: begin
        if (TO_EN) cnt_d = cnt_inc;
        if (wb_ack_i) begin
          state_d     = IDLE;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? '0 : wb_dat_i;
        end else if (TO_EN && (cnt_inc == CNT_TERM)) begin
          state_d     = IDLE;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = we_q ? '0 : ERR_DATA;
        end
      end

      LOCAL: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
      end

      default: state_d = IDLE;
    endcase

    if (req_en_i && (state_q != IDLE)) begin
      if (!pend_valid_q) begin
        pend_valid_d  = 1'b1;
        pend_we_d     = req_we_i;
        pend_addr_d   = req_addr_i;
        pend_wdata_d  = req_wdata_i;
        pend_strobe_d = req_strobe_i;
      end else begin
        overflow_d = 1'b1;
      end
    end

    busy_d = (state_d != IDLE) || pend_valid_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      pend_valid_q  <= 1'b0;
      pend_we_q     <= 1'b0;
      pend_addr_q   <= '0;
      pend_wdata_q  <= '0;
      pend_strobe_q <= '0;
      cyc_q         <= 1'b0;
      we_q          <= 1'b0;
      sel_q         <= '0;
      adr_q         <= '0;
      dat_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      busy_q        <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pend_valid_q  <= pend_valid_d;
      pend_we_q     <= pend_we_d;
      pend_addr_q   <= pend_addr_d;
      pend_wdata_q  <= pend_wdata_d;
      pend_strobe_q <= pend_strobe_d;
      cyc_q         <= cyc_d;
      we_q          <= we_d;
      sel_q         <= sel_d;
      adr_q         <= adr_d;
      dat_q         <= dat_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      busy_q        <= busy_d;
      overflow_q    <= overflow_d;
    end
  end

  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_we_o     = we_q;
  assign wb_sel_o    = sel_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign busy_o      = busy_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_aukv_wb_data_bridge.sv
// Directed self-checking bench for aukv_wb_data_bridge (timeout shortened to 8 cycles).
module tb_aukv_wb_data_bridge;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        req_en_i, req_we_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [3:0]  req_strobe_i;
  logic        rsp_valid_o, rsp_err_o, busy_o, overflow_o;
  logic [31:0] rsp_rdata_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic        wb_ack_i;

  int n_checks = 0;
  int n_errors = 0;

  aukv_wb_data_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8), .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .req_en_i(req_en_i), .req_we_i(req_we_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_strobe_i(req_strobe_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .busy_o(busy_o), .overflow_o(overflow_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Presents one request for a single cycle; returns 1 ns after the accepting edge.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strobe);
    req_en_i = 1'b1; req_we_i = we; req_addr_i = addr;
    req_wdata_i = wdata; req_strobe_i = strobe;
    tick();
    req_en_i = 1'b0;
  endtask

  // Holds ack low for wait_n cycles then acks once; n counts cycles with cyc&stb high.
  task automatic serve(input int wait_n, input logic [31:0] rd, output int n);
    n = 0;
    for (int i = 0; i < wait_n; i++) begin
      if (wb_cyc_o && wb_stb_o) n++;
      tick();
    end
    if (wb_cyc_o && wb_stb_o) n++;
    wb_ack_i = 1'b1; wb_dat_i = rd;
    tick();
    wb_ack_i = 1'b0; wb_dat_i = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic quiet;

    rst_n = 1'b0; req_en_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0;
    req_wdata_i = '0; req_strobe_i = '0; wb_dat_i = '0; wb_ack_i = 1'b0;
    #1;
    check("reset_cyc", wb_cyc_o, 1'b0);
    check("reset_stb", wb_stb_o, 1'b0);
    check("reset_valid", rsp_valid_o, 1'b0);
    check("reset_busy", busy_o, 1'b0);
    check("reset_ovf", overflow_o, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single read, ack two cycles after stb rises.
    issue(1'b0, 32'h0000_0010, 32'h0, 4'h0);
    check("rd_cyc", wb_cyc_o, 1'b1);
    check("rd_we", wb_we_o, 1'b0);
    check("rd_sel", wb_sel_o, 4'hF);
    check("rd_adr", wb_adr_o, 32'h0000_0010);
    check("rd_busy", busy_o, 1'b1);
    serve(2, 32'h1234_5678, n);
    check("rd_cyc_len", n, 3);
    check("rd_valid", rsp_valid_o, 1'b1);
    check("rd_rdata", rsp_rdata_o, 32'h1234_5678);
    check("rd_err", rsp_err_o, 1'b0);
    check("rd_cyc_drop", wb_cyc_o, 1'b0);
    tick();
    check("rd_valid_pulse", rsp_valid_o, 1'b0);

    // Write with partial strobe, immediate ack.
    issue(1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'b0011);
    check("wr_we", wb_we_o, 1'b1);
    check("wr_sel", wb_sel_o, 4'h3);
    check("wr_dat", wb_dat_o, 32'hCAFE_F00D);
    check("wr_adr", wb_adr_o, 32'h0000_0020);
    serve(0, 32'hFFFF_FFFF, n);
    check("wr_valid", rsp_valid_o, 1'b1);
    check("wr_rdata", rsp_rdata_o, 32'h0);
    tick();
    check("wr_valid_pulse", rsp_valid_o, 1'b0);

    // Zero-strobe write: LOCAL, no bus cycle.
    issue(1'b1, 32'h0000_0030, 32'h1111_2222, 4'b0000);
    check("loc_cyc", wb_cyc_o, 1'b0);
    check("loc_busy", busy_o, 1'b1);
    tick();
    check("loc_valid", rsp_valid_o, 1'b1);
    check("loc_rdata", rsp_rdata_o, 32'h0);
    check("loc_err", rsp_err_o, 1'b0);
    check("loc_cyc2", wb_cyc_o, 1'b0);
    tick();

    // Read timeout: cyc high for exactly 8 cycles, then error response.
    issue(1'b0, 32'h0000_0040, 32'h0, 4'h0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (wb_cyc_o && wb_stb_o) n++;
      tick();
    end
    check("to_cyc_len", n, 8);
    check("to_cyc_drop", wb_cyc_o, 1'b0);
    check("to_valid", rsp_valid_o, 1'b1);
    check("to_err", rsp_err_o, 1'b1);
    check("to_rdata", rsp_rdata_o, 32'hDEAD_BEEF);
    tick();

    // Write timeout returns zero data with the error flag.
    issue(1'b1, 32'h0000_0044, 32'h9999_0000, 4'hF);
    for (int i = 0; i < 8; i++) tick();
    check("to_wr_err", rsp_err_o, 1'b1);
    check("to_wr_rdata", rsp_rdata_o, 32'h0);
    tick();

    // Ack on the terminal cycle wins over the timeout.
    issue(1'b0, 32'h0000_0048, 32'h0, 4'h0);
    serve(7, 32'h55AA_55AA, n);
    check("ack8_cyc_len", n, 8);
    check("ack8_valid", rsp_valid_o, 1'b1);
    check("ack8_err", rsp_err_o, 1'b0);
    check("ack8_rdata", rsp_rdata_o, 32'h55AA_55AA);
    tick();

    // Three consecutive requests with a slow slave: third dropped.
    issue(1'b0, 32'h0000_0100, 32'h0, 4'h0);
    issue(1'b0, 32'h0000_0104, 32'h0, 4'h0);
    issue(1'b0, 32'h0000_0108, 32'h0, 4'h0);
    check("b2b_ovf", overflow_o, 1'b1);
    check("b2b_busy", busy_o, 1'b1);
    check("b2b_adr_a", wb_adr_o, 32'h0000_0100);
    serve(1, 32'hAAAA_0001, n);
    check("b2b_rdata_a", rsp_rdata_o, 32'hAAAA_0001);
    check("b2b_gap", wb_cyc_o, 1'b0);
    check("b2b_busy_pend", busy_o, 1'b1);
    tick();
    check("b2b_cyc_b", wb_cyc_o, 1'b1);
    check("b2b_adr_b", wb_adr_o, 32'h0000_0104);
    serve(3, 32'hBBBB_0002, n);
    check("b2b_len_b", n, 4);
    check("b2b_rdata_b", rsp_rdata_o, 32'hBBBB_0002);
    check("b2b_busy_done", busy_o, 1'b0);
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (wb_cyc_o || rsp_valid_o) quiet = 1'b0;
    end
    check("b2b_no_third", quiet, 1'b1);
    check("b2b_ovf_sticky", overflow_o, 1'b1);

    // Reset mid-ACTIVE with the pending slot full.
    issue(1'b0, 32'h0000_0200, 32'h0, 4'h0);
    issue(1'b0, 32'h0000_0204, 32'h0, 4'h0);
    check("rst_pre_cyc", wb_cyc_o, 1'b1);
    check("rst_pre_busy", busy_o, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_cyc", wb_cyc_o, 1'b0);
    check("rst_stb", wb_stb_o, 1'b0);
    check("rst_valid", rsp_valid_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_ovf", overflow_o, 1'b0);
    tick();
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (wb_cyc_o || rsp_valid_o || busy_o) quiet = 1'b0;
    end
    check("rst_no_replay", quiet, 1'b1);
    issue(1'b0, 32'h0000_0300, 32'h0, 4'h0);
    check("rst_fresh_adr", wb_adr_o, 32'h0000_0300);
    serve(0, 32'h0000_0300, n);
    check("rst_fresh_rdata", rsp_rdata_o, 32'h0000_0300);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aukv_wb_data_bridge.md
Name: aukv_wb_data_bridge

Overview:
- Bridges the aukv core's native data-memory port (en/we/addr/data/strobe in; valid/data out) to a Wishbone classic master on the data_mem bus of processorci_top.
- Sits directly downstream of the core's o_data_mem_* / i_data_mem_* pins and upstream of the Controller's data_mem_* Wishbone slave.
- Adds a one-entry pending buffer, a per-transaction timeout with an error response, and a local fast path for zero-strobe writes.

Parameters:
- ADDR_WIDTH, 32, width of the native and Wishbone address.
- DATA_WIDTH, 32, data width; SEL width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 256, maximum ACTIVE cycles before forced termination; 0 disables the timeout.
- ERR_DATA, 32'hDEAD_BEEF, value returned on rsp_rdata_o for a timed-out read.

Ports:
- sys_clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_en_i  in  1  native request strobe; one request per cycle in which it is high.
- req_we_i  in  1  1 = write, 0 = read.
- req_addr_i  in  ADDR_WIDTH  byte address.
- req_wdata_i  in  DATA_WIDTH  write data.
- req_strobe_i  in  DATA_WIDTH/8  write byte enables.
- rsp_valid_o  out  1  one-cycle response pulse.
- rsp_rdata_o  out  DATA_WIDTH  read data, valid with rsp_valid_o.
- rsp_err_o  out  1  timeout flag, valid with rsp_valid_o.
- busy_o  out  1  high when state != IDLE or the pending slot is full.
- overflow_o  out  1  sticky: a request was dropped.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone master controls.
- wb_sel_o  out  DATA_WIDTH/8  byte select.
- wb_adr_o  out  ADDR_WIDTH  address.
- wb_dat_o  out  DATA_WIDTH  write data.
- wb_dat_i  in  DATA_WIDTH  read data.
- wb_ack_i  in  1  acknowledge.

Behaviour:
- Interface (already decided): one clock, sys_clk; reset rst_n is asynchronous and active-low.
- Reset: every output goes to 0 immediately on assertion, including mid-transaction. State returns to IDLE; the pending slot, the timeout counter and overflow_o are cleared.
- All outputs are registered.
- FSM states: IDLE, ACTIVE, LOCAL.
- IDLE, request selection: the pending entry is served first if present; otherwise req_en_i.
- IDLE, zero-strobe write: a write whose strobe is all zero goes to LOCAL and issues no bus cycle.
- IDLE, normal request: goes to ACTIVE. wb_cyc_o and wb_stb_o rise on the next edge (request in cycle N, bus in N+1).
- Bus fields: wb_sel_o = req_strobe_i for writes and all ones for reads. Address and data are passed unmodified.
- ACTIVE: cyc, stb, we, sel, adr and dat are held stable; the timeout counter increments every cycle.
- ACTIVE, ack: on a cycle with wb_ack_i high, the next edge drops cyc/stb and asserts rsp_valid_o for exactly one cycle, then returns to IDLE.
  - rsp_rdata_o = wb_dat_i captured at that edge for reads, 0 for writes.
  - rsp_err_o = 0.
- ACTIVE, timeout: when the counter reaches TIMEOUT_CYCLES without an ack, the next edge drops cyc/stb and pulses rsp_valid_o with rsp_err_o = 1.
  - rsp_rdata_o = ERR_DATA for a read, 0 for a write.
- Ack and terminal count in the same cycle: ack wins, no error.
- LOCAL: rsp_valid_o pulses on the next edge with rdata 0 and err 0, then returns to IDLE.
- Back-to-back requests: cyc is low for at least one cycle between any two transactions.
- req_en_i while not accepting: the request goes into the empty pending slot. If the slot is full, the request is dropped and overflow_o is set (sticky until reset).
- req_en_i in IDLE with the pending slot full: the pending entry launches and the new request refills the slot in the same edge; nothing is dropped.
- wb_ack_i outside ACTIVE is ignored.
- Counter width: clog2(TIMEOUT_CYCLES+1). The counter never wraps and is cleared on entry to ACTIVE.

Test Plan:
- Single read at 0x0000_0010, slave acks 2 cycles after stb with 0x1234_5678 -> cyc/stb high for 3 cycles, sel = 0xF, then rsp_valid_o one cycle with rdata = 0x1234_5678, err = 0.
- Write 0xCAFE_F00D at 0x20, strobe 4'b0011, immediate ack -> wb_we = 1, sel = 0x3, dat = 0xCAFE_F00D, rsp_valid_o one cycle later, rdata = 0.
- Three req_en_i pulses on consecutive cycles with a slow slave (ack after 4 cycles) -> the first two complete in order with an idle cyc cycle between them; the third is dropped and overflow_o = 1 stays set.
- TIMEOUT_CYCLES = 8, read with no ack -> stb deasserts after 8 ACTIVE cycles; rsp_valid_o with err = 1 and rdata = 0xDEAD_BEEF. Repeat with ack on exactly cycle 8 -> err = 0.
- Write with strobe 0 -> no cyc assertion; rsp_valid_o on the next edge.
- Assert rst_n low mid-ACTIVE with pending full -> cyc/stb/rsp_valid_o/busy_o go to 0 asynchronously; after release, no stale transaction is replayed.
